// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and types for the SRAM port arbiter.
package fb_pkg;

    localparam int H_RES        = 320;
    localparam int V_RES        = 240;
    localparam int ADDR_W       = 17;
    localparam int PIX_W        = 16;
    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int FRAME_PIX    = H_RES * V_RES;

    localparam logic [PIX_W-1:0] CLR_COLOR = 16'h0000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_e;

    // Linear pixel address; only meaningful for in-frame coordinates.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [15:0] x, input logic [15:0] y);
        return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous write FIFO holding {address, pixel} entries for the SRAM port.
module fb_wr_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[PTR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer SRAM port arbiter: windowed pixel writes via a FIFO, full-frame clear,
// and HDMI line-fetch reads with priority bounded by a starvation guard.
module fb_port_arbiter
    import fb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [PIX_W-1:0]  i_pixel_data,
    input  logic [31:0]       i_col_addr,
    input  logic [31:0]       i_row_addr,
    input  logic              i_wr_req,
    input  logic              i_waddr_set_req,
    input  logic              i_clr_req,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic [PIX_W-1:0]  o_rd_data,
    output logic              o_rd_valid,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [PIX_W-1:0]  o_mem_wdata,
    input  logic [PIX_W-1:0]  i_mem_rdata,
    output logic              o_busy,
    output logic              o_ovf
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int ENTRY_W  = ADDR_W + PIX_W;

    fb_state_e           state;
    fb_state_e           state_nxt;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [ADDR_W-1:0]   clr_cnt_nxt;
    logic [STARVE_W-1:0] starve_cnt;
    logic [15:0]         cur_x;
    logic [15:0]         cur_y;
    logic [15:0]         win_xs;
    logic [15:0]         win_xe;
    logic [15:0]         win_ys;
    logic [15:0]         win_ye;

    logic                in_frame;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_wdata;
    logic [ENTRY_W-1:0]  fifo_rdata;
    logic                wr_pending;
    logic                starve_force;
    logic                wr_grant;
    logic                ovf_set;

    assign {win_xs, win_xe} = i_col_addr;
    assign {win_ys, win_ye} = i_row_addr;

    assign in_frame     = (cur_x < 16'(H_RES)) && (cur_y < 16'(V_RES));
    assign wr_pending   = (state == ST_CLEAR) || !fifo_empty;
    assign starve_force = wr_pending && (starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign wr_grant     = wr_pending && (starve_force || !i_rd_req);
    assign o_rd_ack     = i_rd_req && !starve_force;

    // While clearing, the clear counter owns the write slot and FIFO entries wait.
    assign fifo_pop   = wr_grant && (state == ST_IDLE);
    assign fifo_push  = i_wr_req && in_frame && (!fifo_full || fifo_pop) && !i_clr_req;
    assign ovf_set    = i_wr_req && in_frame && fifo_full && !fifo_pop;
    assign fifo_wdata = {pix_addr(cur_x, cur_y), i_pixel_data};

    fb_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .flush   (i_clr_req),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (fifo_wdata),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (wr_grant) begin
            o_mem_en = 1'b1;
            o_mem_we = 1'b1;
            if (state == ST_CLEAR) begin
                o_mem_addr  = clr_cnt;
                o_mem_wdata = CLR_COLOR;
            end else begin
                {o_mem_addr, o_mem_wdata} = fifo_rdata;
            end
        end else if (o_rd_ack) begin
            o_mem_en   = 1'b1;
            o_mem_addr = i_rd_addr;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        if (i_clr_req) begin
            state_nxt   = ST_CLEAR;
            clr_cnt_nxt = '0;
        end else if ((state == ST_CLEAR) && wr_grant) begin
            if (clr_cnt == ADDR_W'(FRAME_PIX - 1)) state_nxt = ST_IDLE;
            else                                   clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if (!wr_pending || wr_grant) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    // A same-cycle reload wins over the advance; the write itself already used the old cursor.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cur_x <= '0;
            cur_y <= '0;
        end else if (i_waddr_set_req) begin
            cur_x <= win_xs;
            cur_y <= win_ys;
        end else if (i_wr_req) begin
            if (cur_x == win_xe) begin
                cur_x <= win_xs;
                cur_y <= (cur_y == win_ye) ? win_ys : cur_y + 16'd1;
            end else begin
                cur_x <= cur_x + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf <= 1'b0;
        end else if (i_clr_req) begin
            o_ovf <= 1'b0;
        end else if (ovf_set) begin
            o_ovf <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= o_rd_ack;
            if (o_rd_ack) o_rd_data <= i_mem_rdata;
        end
    end

    assign o_busy = (state == ST_CLEAR) || !fifo_empty;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_fb_port_arbiter;
    import fb_pkg::*;

    localparam int FRAME = H_RES * V_RES;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [15:0]       i_pixel_data = '0;
    logic [31:0]       i_col_addr = '0;
    logic [31:0]       i_row_addr = '0;
    logic              i_wr_req = 1'b0;
    logic              i_waddr_set_req = 1'b0;
    logic              i_clr_req = 1'b0;
    logic              i_rd_req = 1'b0;
    logic [ADDR_W-1:0] i_rd_addr = '0;
    logic              o_rd_ack;
    logic [15:0]       o_rd_data;
    logic              o_rd_valid;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [15:0]       o_mem_wdata;
    logic [15:0]       i_mem_rdata;
    logic              o_busy;
    logic              o_ovf;

    fb_port_arbiter dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_pixel_data    (i_pixel_data),
        .i_col_addr      (i_col_addr),
        .i_row_addr      (i_row_addr),
        .i_wr_req        (i_wr_req),
        .i_waddr_set_req (i_waddr_set_req),
        .i_clr_req       (i_clr_req),
        .i_rd_req        (i_rd_req),
        .i_rd_addr       (i_rd_addr),
        .o_rd_ack        (o_rd_ack),
        .o_rd_data       (o_rd_data),
        .o_rd_valid      (o_rd_valid),
        .o_mem_en        (o_mem_en),
        .o_mem_we        (o_mem_we),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wdata     (o_mem_wdata),
        .i_mem_rdata     (i_mem_rdata),
        .o_busy          (o_busy),
        .o_ovf           (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    // Stand-in SRAM contents: a fixed scramble of the address.
    function automatic logic [15:0] sram_word(input logic [ADDR_W-1:0] a);
        return 16'(32'(a) * 32'd7) ^ 16'hC35A;
    endfunction

    assign i_mem_rdata = sram_word(o_mem_addr);

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         m_q[$];
    logic [15:0] m_x;
    logic [15:0] m_y;
    int          m_wait;
    bit          m_clear;
    int          m_clr_cnt;
    bit          m_ovf;
    bit          m_valid;
    logic [15:0] m_rd_data;
    bit          model_on = 1'b0;

    int wr_count = 0;
    int wr_log[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_x = '0;
        m_y = '0;
        m_wait = 0;
        m_clear = 1'b0;
        m_clr_cnt = 0;
        m_ovf = 1'b0;
        m_valid = 1'b0;
        m_rd_data = '0;
    endtask

    // One cycle of the reference: predict this cycle's port activity, then apply the edge.
    task automatic model_step();
        bit          pending;
        bit          force_wr;
        bit          exp_wr;
        bit          exp_ack;
        logic [31:0] exp_addr;
        logic [15:0] exp_wdata;
        wr_t         ent;

        pending  = m_clear || (m_q.size() != 0);
        force_wr = pending && (m_wait == STARVE_LIMIT);
        exp_wr   = pending && (force_wr || !i_rd_req);
        exp_ack  = i_rd_req && !force_wr;
        exp_addr = '0;
        exp_wdata = '0;
        if (exp_wr) begin
            if (m_clear) begin
                exp_addr  = 32'(m_clr_cnt);
                exp_wdata = CLR_COLOR;
            end else begin
                exp_addr  = m_q[0].addr;
                exp_wdata = m_q[0].data;
            end
        end else if (exp_ack) begin
            exp_addr = 32'(i_rd_addr);
        end

        check("mem_en", 32'(o_mem_en), 32'(exp_wr || exp_ack));
        check("mem_we", 32'(o_mem_we), 32'(exp_wr));
        check("rd_ack", 32'(o_rd_ack), 32'(exp_ack));
        if (exp_wr || exp_ack) check("mem_addr", 32'(o_mem_addr), exp_addr);
        if (exp_wr) check("mem_wdata", 32'(o_mem_wdata), 32'(exp_wdata));
        check("busy", 32'(o_busy), 32'(pending));
        check("ovf", 32'(o_ovf), 32'(m_ovf));
        check("rd_valid", 32'(o_rd_valid), 32'(m_valid));
        if (m_valid) check("rd_data", 32'(o_rd_data), 32'(m_rd_data));

        if (o_mem_en && o_mem_we) begin
            wr_count++;
            wr_log.push_back(int'(o_mem_addr));
        end

        m_valid = exp_ack;
        if (exp_ack) m_rd_data = sram_word(i_rd_addr);
        m_wait = (exp_wr || !pending) ? 0 : m_wait + 1;
        if (exp_wr && !m_clear) void'(m_q.pop_front());
        if (exp_wr && m_clear) begin
            if (m_clr_cnt == FRAME - 1) m_clear = 1'b0;
            else                        m_clr_cnt++;
        end
        if (i_wr_req) begin
            if (m_x < H_RES && m_y < V_RES) begin
                if (m_q.size() < FIFO_DEPTH) begin
                    ent.addr = 32'(m_y) * 32'(H_RES) + 32'(m_x);
                    ent.data = i_pixel_data;
                    m_q.push_back(ent);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (m_x == i_col_addr[15:0]) begin
                m_x = i_col_addr[31:16];
                m_y = (m_y == i_row_addr[15:0]) ? i_row_addr[31:16] : m_y + 16'd1;
            end else begin
                m_x = m_x + 16'd1;
            end
        end
        if (i_waddr_set_req) begin
            m_x = i_col_addr[31:16];
            m_y = i_row_addr[31:16];
        end
        if (i_clr_req) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_clear = 1'b1;
            m_clr_cnt = 0;
        end
    endtask

    always @(negedge i_clk) begin
        if (model_on) model_step();
    end

    task automatic step();
        @(posedge i_clk);
        #1;
        i_wr_req = 1'b0;
        i_waddr_set_req = 1'b0;
        i_clr_req = 1'b0;
    endtask

    task automatic set_window(input logic [15:0] xs, input logic [15:0] xe,
                              input logic [15:0] ys, input logic [15:0] ye);
        i_col_addr = {xs, xe};
        i_row_addr = {ys, ye};
        i_waddr_set_req = 1'b1;
        step();
    endtask

    task automatic wr(input logic [15:0] pix);
        i_pixel_data = pix;
        i_wr_req = 1'b1;
        step();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_mem_en"}, 32'(o_mem_en), 32'd0);
        check({phase, "_mem_we"}, 32'(o_mem_we), 32'd0);
        check({phase, "_mem_addr"}, 32'(o_mem_addr), 32'd0);
        check({phase, "_mem_wdata"}, 32'(o_mem_wdata), 32'd0);
        check({phase, "_rd_ack"}, 32'(o_rd_ack), 32'd0);
        check({phase, "_rd_valid"}, 32'(o_rd_valid), 32'd0);
        check({phase, "_rd_data"}, 32'(o_rd_data), 32'd0);
        check({phase, "_busy"}, 32'(o_busy), 32'd0);
        check({phase, "_ovf"}, 32'(o_ovf), 32'd0);
    endtask

    initial begin
        int exp_win[5];
        int exp_ovf[5];
        logic [15:0] xs;
        logic [15:0] ys;

        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_rst_n = 1'b1;
        model_on = 1'b1;
        step();

        // Window walk with row wrap and window wrap.
        wr_log.delete();
        set_window(16'd2, 16'd3, 16'd5, 16'd6);
        for (int i = 0; i < 5; i++) wr(16'h1000 + 16'(i));
        wait_idle(50);
        exp_win = '{1602, 1603, 1922, 1923, 1602};
        check("win_count", 32'(wr_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check("win_addr", (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hFFFF_FFFF, 32'(exp_win[i]));

        // Right edge crossing: out-of-frame columns are dropped silently.
        wr_log.delete();
        set_window(16'd318, 16'd321, 16'd0, 16'd0);
        for (int i = 0; i < 4; i++) wr(16'h2000 + 16'(i));
        wait_idle(50);
        check("edge_count", 32'(wr_log.size()), 32'd2);
        check("edge_addr0", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hFFFF_FFFF, 32'd318);
        check("edge_addr1", (wr_log.size() > 1) ? 32'(wr_log[1]) : 32'hFFFF_FFFF, 32'd319);
        check("edge_ovf", 32'(o_ovf), 32'd0);

        // Starvation guard: one pending entry under continuous reads.
        set_window(16'd40, 16'd60, 16'd100, 16'd100);
        i_rd_req = 1'b1;
        i_rd_addr = ADDR_W'($urandom);
        wr(16'hBEEF);
        for (int k = 1; k <= 11; k++) begin
            #1;
            check("starve_ack", 32'(o_rd_ack), 32'(k != 9));
            check("starve_we", 32'(o_mem_we), 32'(k == 9));
            check("starve_valid", 32'(o_rd_valid), 32'(k != 10));
            i_rd_addr = ADDR_W'($urandom);
            step();
        end
        i_rd_req = 1'b0;
        wait_idle(50);

        // Overflow: six back-to-back writes while reads hold the port.
        wr_log.delete();
        i_rd_req = 1'b1;
        set_window(16'd10, 16'd200, 16'd7, 16'd9);
        for (int i = 0; i < 6; i++) wr(16'h3000 + 16'(i));
        #1;
        check("ovf_set", 32'(o_ovf), 32'd1);
        step();
        i_rd_req = 1'b0;
        wait_idle(50);
        check("ovf_sticky", 32'(o_ovf), 32'd1);
        wr(16'h3100);
        wait_idle(50);
        exp_ovf = '{7 * H_RES + 10, 7 * H_RES + 11, 7 * H_RES + 12, 7 * H_RES + 13, 7 * H_RES + 16};
        check("ovf_count", 32'(wr_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check("ovf_addr", (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hFFFF_FFFF, 32'(exp_ovf[i]));

        // Full-frame clear with no reads.
        wr_log.delete();
        wr_count = 0;
        i_clr_req = 1'b1;
        step();
        check("clr_busy", 32'(o_busy), 32'd1);
        check("clr_ovf_cleared", 32'(o_ovf), 32'd0);
        wait_idle(FRAME + 100);
        check("clr_count", 32'(wr_count), 32'(FRAME));
        check("clr_first", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hFFFF_FFFF, 32'd0);
        check("clr_last", (wr_log.size() > 0) ? 32'(wr_log[wr_log.size() - 1]) : 32'hFFFF_FFFF,
              32'(FRAME - 1));
        wr_log.delete();

        // Random traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 29) == 0) begin
                xs = 16'($urandom_range(0, 330));
                ys = 16'($urandom_range(0, 245));
                i_col_addr = {xs, xs + 16'($urandom_range(0, 12))};
                i_row_addr = {ys, ys + 16'($urandom_range(0, 3))};
                i_waddr_set_req = 1'b1;
            end
            i_wr_req = ($urandom_range(0, 9) < 4);
            i_pixel_data = 16'($urandom);
            i_rd_req = ($urandom_range(0, 9) < 6);
            i_rd_addr = ADDR_W'($urandom);
            step();
        end
        i_rd_req = 1'b0;
        wait_idle(100);
        wr_log.delete();

        // Reset in the middle of a clear.
        i_clr_req = 1'b1;
        step();
        repeat (1000) step();
        #1;
        check("clr_mid_addr", 32'(o_mem_addr), 32'd1000);
        model_on = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        repeat (3) step();
        i_rst_n = 1'b1;
        model_on = 1'b1;
        wr_count = 0;
        repeat (20) step();
        check("post_rst_writes", 32'(wr_count), 32'd0);
        check("post_rst_busy", 32'(o_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
